// File: rtl/pong_pkg.sv
// Shared pong geometry, clock constants and ball FSM state encoding.
// Paddle overlap helper used by the ball physics stage.
package pong_pkg;

    localparam int H_VIDEO    = 640;
    localparam int V_VIDEO    = 480;
    localparam int SQ_WIDTH   = 16;
    localparam int PDL_HEIGHT = 96;
    localparam int PDL_WIDTH  = 16;
    localparam int P1_X       = 16;
    localparam int P2_X       = 608;
    localparam int CLK_HZ     = 25_175_000;

    localparam logic [9:0] SQ_X_MAX = 10'(H_VIDEO - SQ_WIDTH);
    localparam logic [9:0] SQ_Y_MAX = 10'(V_VIDEO - SQ_WIDTH);
    localparam logic [9:0] SQ_X_C   = 10'((H_VIDEO - SQ_WIDTH) / 2);
    localparam logic [9:0] SQ_Y_C   = 10'((V_VIDEO - SQ_WIDTH) / 2);
    localparam logic [9:0] P1_FACE  = 10'(P1_X + PDL_WIDTH);
    localparam logic [10:0] P2_FACE = 11'(P2_X);

    typedef enum logic [1:0] {
        SERVE  = 2'd0,
        MOVING = 2'd1,
        MISSED = 2'd2
    } state_t;

    // Strict overlap: edge-touching rows do not count as a hit.
    function automatic logic pdl_overlap(
        input logic [9:0] sq_y,
        input logic [9:0] pdl_y
    );
        logic [10:0] sq_bot;
        logic [10:0] pdl_bot;
        sq_bot  = {1'b0, sq_y} + 11'(SQ_WIDTH);
        pdl_bot = {1'b0, pdl_y} + 11'(PDL_HEIGHT);
        return (sq_bot > {1'b0, pdl_y}) && ({1'b0, sq_y} < pdl_bot);
    endfunction

endpackage

// File: rtl/rate_tick.sv
// Programmable-period prescaler: one-cycle tick every i_period enabled cycles.
// Counter holds while disabled; i_clr restarts the period.
module rate_tick #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_period,
    output logic         o_tick
);

    logic [W-1:0] r_cnt;
    logic         w_last;

    // >= keeps the tick alive if the period shrinks below the count.
    assign w_last = (r_cnt >= i_period - W'(1));
    assign o_tick = i_en && !i_clr && w_last;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Ball physics: wall/paddle bounces, misses and timed serve from centre.
// Define BALL_SPEEDUP_EN to shorten the step period on each paddle hit.
module ball_motion
    import pong_pkg::*;
#(
    parameter int CLK_HZ      = pong_pkg::CLK_HZ,
    parameter int SPEED       = 300,
    parameter int SERVE_DELAY = 1000
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       reset_game,
    input  logic       game_en,
    input  logic [9:0] p1_ypos,
    input  logic [9:0] ai_ypos,
    output logic [9:0] sq_xpos,
    output logic [9:0] sq_ypos,
    output logic       sq_xveldir,
    output logic       sq_yveldir,
    output logic       sq_missed,
    output logic       miss_side,
    output logic       pdl_hit
);

    localparam logic [31:0] STEP_BASE = 32'(CLK_HZ / SPEED);
    localparam logic [31:0] SERVE_CYC = 32'(SERVE_DELAY * (CLK_HZ / 1000));

    state_t      r_state;
    state_t      w_state_next;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic        r_xdir;
    logic        r_ydir;
    logic        r_missed;
    logic        r_miss_side;
    logic        r_pdl_hit;
    logic [5:0]  r_lfsr;

    logic        w_serve_en;
    logic        w_serve_clr;
    logic        w_serve_tick;
    logic        w_step_en;
    logic        w_step_clr;
    logic        w_step_tick;
    logic [31:0] w_step_period;

    logic        w_ai_hit;
    logic        w_p1_hit;
    logic        w_miss_r;
    logic        w_miss_l;
    logic        w_miss;

    assign w_ai_hit = r_xdir
                   && ({1'b0, r_x} + 11'(SQ_WIDTH) == P2_FACE)
                   && pdl_overlap(r_y, ai_ypos);
    assign w_p1_hit = !r_xdir
                   && (r_x == P1_FACE)
                   && pdl_overlap(r_y, p1_ypos);
    assign w_miss_r = r_xdir && !w_ai_hit && (r_x == SQ_X_MAX);
    assign w_miss_l = !r_xdir && !w_p1_hit && (r_x == 10'd0);
    assign w_miss   = w_miss_r || w_miss_l;

    always_ff @(posedge clk_0) begin
        if (rst) begin
            r_state <= SERVE;
        end else if (reset_game) begin
            r_state <= SERVE;
        end else if (game_en) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            SERVE:   if (w_serve_tick) w_state_next = MOVING;
            MOVING:  if (w_step_tick && w_miss) w_state_next = MISSED;
            MISSED:  w_state_next = SERVE;
            default: w_state_next = SERVE;
        endcase
    end

    always_comb begin
        w_serve_en  = game_en && (r_state == SERVE);
        w_step_en   = game_en && (r_state == MOVING);
        w_serve_clr = rst || reset_game || (r_state != SERVE);
        w_step_clr  = rst || reset_game || (r_state != MOVING);
    end

    rate_tick #(.W(32)) u_serve (
        .i_clk    (clk_0),
        .i_clr    (w_serve_clr),
        .i_en     (w_serve_en),
        .i_period (SERVE_CYC),
        .o_tick   (w_serve_tick)
    );

    rate_tick #(.W(32)) u_step (
        .i_clk    (clk_0),
        .i_clr    (w_step_clr),
        .i_en     (w_step_en),
        .i_period (w_step_period),
        .o_tick   (w_step_tick)
    );

`ifdef BALL_SPEEDUP_EN
    logic [3:0]  r_hits;
    logic [31:0] w_cut;

    // Eight hits take base - 8*base/16 = base/2, the clamp point.
    assign w_cut         = (STEP_BASE * {28'd0, r_hits}) >> 4;
    assign w_step_period = STEP_BASE - w_cut;

    always_ff @(posedge clk_0) begin
        if (rst || reset_game) begin
            r_hits <= '0;
        end else if (game_en) begin
            if (r_state == MISSED) begin
                r_hits <= '0;
            end else if (w_step_tick && (w_ai_hit || w_p1_hit)
                         && (r_hits != 4'd8)) begin
                r_hits <= r_hits + 4'd1;
            end
        end
    end
`else
    assign w_step_period = STEP_BASE;
`endif

    always_ff @(posedge clk_0) begin
        if (rst) begin
            r_lfsr <= 6'h1F;
        end else begin
            r_lfsr <= {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[4]};
        end
    end

    always_ff @(posedge clk_0) begin
        if (rst || reset_game) begin
            r_x         <= SQ_X_C;
            r_y         <= SQ_Y_C;
            r_xdir      <= 1'b0;
            r_ydir      <= 1'b0;
            r_missed    <= 1'b0;
            r_miss_side <= 1'b0;
            r_pdl_hit   <= 1'b0;
        end else begin
            r_missed  <= 1'b0;
            r_pdl_hit <= 1'b0;
            if (game_en) begin
                unique case (r_state)
                    SERVE: begin
                        r_x <= SQ_X_C;
                        r_y <= SQ_Y_C;
                        if (w_serve_tick) r_ydir <= r_lfsr[0];
                    end
                    MOVING: begin
                        if (w_step_tick) begin
                            if (r_ydir && (r_y == SQ_Y_MAX)) begin
                                r_ydir <= 1'b0;
                                r_y    <= r_y - 10'd1;
                            end else if (!r_ydir && (r_y == 10'd0)) begin
                                r_ydir <= 1'b1;
                                r_y    <= r_y + 10'd1;
                            end else begin
                                r_y <= r_ydir ? r_y + 10'd1 : r_y - 10'd1;
                            end

                            if (w_ai_hit) begin
                                r_xdir    <= 1'b0;
                                r_x       <= r_x - 10'd1;
                                r_pdl_hit <= 1'b1;
                            end else if (w_p1_hit) begin
                                r_xdir    <= 1'b1;
                                r_x       <= r_x + 10'd1;
                                r_pdl_hit <= 1'b1;
                            end else if (w_miss) begin
                                r_missed    <= 1'b1;
                                r_miss_side <= w_miss_r;
                            end else begin
                                r_x <= r_xdir ? r_x + 10'd1 : r_x - 10'd1;
                            end
                        end
                    end
                    MISSED: begin
                        r_x    <= SQ_X_C;
                        r_y    <= SQ_Y_C;
                        r_xdir <= r_miss_side;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sq_xpos    = r_x;
    assign sq_ypos    = r_y;
    assign sq_xveldir = r_xdir;
    assign sq_yveldir = r_ydir;
    assign sq_missed  = r_missed;
    assign miss_side  = r_miss_side;
    assign pdl_hit    = r_pdl_hit;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: serve timing, paddle hits, wall bounces,
// pause freeze, miss/re-serve and reset_game (tick 10, serve 20 cycles).
module tb_ball_motion;

    logic       clk_0 = 1'b0;
    logic       rst;
    logic       reset_game;
    logic       game_en;
    logic [9:0] p1_ypos;
    logic [9:0] ai_ypos;
    logic [9:0] sq_xpos;
    logic [9:0] sq_ypos;
    logic       sq_xveldir;
    logic       sq_yveldir;
    logic       sq_missed;
    logic       miss_side;
    logic       pdl_hit;

    int checks = 0;
    int errors = 0;
    bit ai_dodge = 1'b0;

    always #5 clk_0 = ~clk_0;

    ball_motion #(
        .CLK_HZ      (1000),
        .SPEED       (100),
        .SERVE_DELAY (20)
    ) dut (
        .clk_0      (clk_0),
        .rst        (rst),
        .reset_game (reset_game),
        .game_en    (game_en),
        .p1_ypos    (p1_ypos),
        .ai_ypos    (ai_ypos),
        .sq_xpos    (sq_xpos),
        .sq_ypos    (sq_ypos),
        .sq_xveldir (sq_xveldir),
        .sq_yveldir (sq_yveldir),
        .sq_missed  (sq_missed),
        .miss_side  (miss_side),
        .pdl_hit    (pdl_hit)
    );

    function automatic logic [9:0] follow(input logic [9:0] y);
        if (y < 10'd40) return 10'd0;
        if (y > 10'd424) return 10'd384;
        return y - 10'd40;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Paddle inputs are stimulus: the player always covers the square,
    // the AI covers it or stays clear depending on ai_dodge.
    task automatic step();
        @(posedge clk_0);
        #1;
        p1_ypos = follow(sq_ypos);
        if (ai_dodge) ai_ypos = (sq_ypos >= 10'd232) ? 10'd0 : 10'd384;
        else          ai_ypos = follow(sq_ypos);
    endtask

    task automatic check_serve(input string tag, input int exp_x);
        int n;
        n = 0;
        while (sq_xpos == 10'd312 && n < 60) begin
            step();
            n++;
        end
        chk({tag, "_cycles"}, n, 30);
        chk({tag, "_x"}, int'(sq_xpos), exp_x);
    endtask

    task automatic wait_pdl(input string tag, input int budget);
        int n;
        n = 0;
        while (!pdl_hit && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_seen"}, int'(pdl_hit), 1);
    endtask

    initial begin
        int n;
        bit got_dn;
        bit got_up;
        logic prev;

        rst        = 1'b1;
        reset_game = 1'b0;
        game_en    = 1'b1;
        p1_ypos    = 10'd0;
        ai_ypos    = 10'd0;
        step();
        step();

        chk("rst_x", int'(sq_xpos), 312);
        chk("rst_y", int'(sq_ypos), 232);
        chk("rst_xdir", int'(sq_xveldir), 0);
        chk("rst_ydir", int'(sq_yveldir), 0);
        chk("rst_missed", int'(sq_missed), 0);
        chk("rst_side", int'(miss_side), 0);
        chk("rst_pdl", int'(pdl_hit), 0);

        rst = 1'b0;
        check_serve("serve0", 311);

        wait_pdl("p1_hit", 8000);
        chk("p1_hit_x", int'(sq_xpos), 33);
        chk("p1_hit_xdir", int'(sq_xveldir), 1);
        step();
        chk("p1_pulse_w", int'(pdl_hit), 0);

        wait_pdl("ai_hit", 8000);
        chk("ai_hit_x", int'(sq_xpos), 591);
        chk("ai_hit_xdir", int'(sq_xveldir), 0);
        step();
        chk("ai_pulse_w", int'(pdl_hit), 0);

        // Tick count now 1; pause at count 3 and expect 7 cycles left.
        step();
        step();
        game_en = 1'b0;
        for (int i = 0; i < 50; i++) step();
        chk("frz_x", int'(sq_xpos), 591);
        chk("frz_pdl", int'(pdl_hit), 0);
        game_en = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("resume_hold_x", int'(sq_xpos), 591);
        step();
        chk("resume_step_x", int'(sq_xpos), 590);

        got_dn = 1'b0;
        got_up = 1'b0;
        n = 0;
        prev = sq_yveldir;
        while (!(got_dn && got_up) && n < 20000) begin
            step();
            n++;
            if (prev && !sq_yveldir && !got_dn) begin
                chk("bot_bounce_y", int'(sq_ypos), 463);
                got_dn = 1'b1;
            end
            if (!prev && sq_yveldir && !got_up) begin
                chk("top_bounce_y", int'(sq_ypos), 1);
                got_up = 1'b1;
            end
            prev = sq_yveldir;
        end
        chk("bounces_seen", int'(got_dn && got_up), 1);

        ai_dodge = 1'b1;
        n = 0;
        while (!sq_missed && n < 15000) begin
            step();
            n++;
        end
        chk("miss_seen", int'(sq_missed), 1);
        chk("miss_x", int'(sq_xpos), 624);
        chk("miss_side", int'(miss_side), 1);
        step();
        chk("miss_pulse_w", int'(sq_missed), 0);
        chk("miss_cx", int'(sq_xpos), 312);
        chk("miss_cy", int'(sq_ypos), 232);
        chk("miss_xdir", int'(sq_xveldir), 1);
        check_serve("serve_miss", 313);

        ai_dodge = 1'b0;
        for (int i = 0; i < 25; i++) step();
        reset_game = 1'b1;
        step();
        chk("rg_x", int'(sq_xpos), 312);
        chk("rg_y", int'(sq_ypos), 232);
        chk("rg_xdir", int'(sq_xveldir), 0);
        chk("rg_ydir", int'(sq_yveldir), 0);
        reset_game = 1'b0;
        check_serve("serve_rg", 311);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
